// File: rtl/write_data_pkg.sv
// Shared definitions for the pixel-pair frame writer and its reader counterpart:
// FSM encodings and the 48-bit pixel-pair packing order.
package write_data_pkg;

  localparam int PAIR_W = 48;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'b00,
    STATE_CAPTURE = 2'b01,
    STATE_DONE    = 2'b10
  } state_t;

  // Odd pixel occupies the upper half so a little-endian byte dump reads B,G,R per pixel.
  function automatic logic [PAIR_W-1:0] pack_pair(
    input logic [7:0] r_even, input logic [7:0] g_even, input logic [7:0] b_even,
    input logic [7:0] r_odd,  input logic [7:0] g_odd,  input logic [7:0] b_odd
  );
    return {r_odd, g_odd, b_odd, r_even, g_even, b_even};
  endfunction

endpackage

// File: rtl/write_data_if.sv
// Pixel-pair stream in, frame-buffer write port and status out.
interface write_data_if
  import write_data_pkg::*;
#(
  parameter int ADDR_WIDTH = 18
);
  logic                  vertical_Pulse;
  logic                  horizontal_Pulse;
  logic [7:0]            data_R_Even;
  logic [7:0]            data_G_Even;
  logic [7:0]            data_B_Even;
  logic [7:0]            data_R_Odd;
  logic [7:0]            data_G_Odd;
  logic [7:0]            data_B_Odd;
  logic                  write_Enable;
  logic [ADDR_WIDTH-1:0] write_Addr;
  logic [PAIR_W-1:0]     write_Data;
  logic                  done_Flag;
  logic                  frame_Error;

  modport master (
    output vertical_Pulse, horizontal_Pulse,
    output data_R_Even, data_G_Even, data_B_Even,
    output data_R_Odd, data_G_Odd, data_B_Odd,
    input  write_Enable, write_Addr, write_Data, done_Flag, frame_Error
  );

  modport slave (
    input  vertical_Pulse, horizontal_Pulse,
    input  data_R_Even, data_G_Even, data_B_Even,
    input  data_R_Odd, data_G_Odd, data_B_Odd,
    output write_Enable, write_Addr, write_Data, done_Flag, frame_Error
  );
endinterface

// File: rtl/write_data_bmp_addr_gen.sv
// Bottom-up (BMP row order) pair address generator: row/col counters plus a
// running row-base register stepped down by one row per wrap instead of a multiply.
module bmp_addr_gen #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  accept,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  end_of_frame
);
  localparam int PAIRS_PER_ROW = IMAGE_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(PAIRS_PER_ROW);
  localparam logic [ADDR_WIDTH-1:0] BASE_FIRST = ADDR_WIDTH'((IMAGE_HEIGHT - 1) * PAIRS_PER_ROW);
  localparam logic [9:0] COL_LAST = 10'(PAIRS_PER_ROW - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMAGE_HEIGHT - 1);

  logic [9:0]            row_q, col_q, row_cur, col_cur;
  logic [ADDR_WIDTH-1:0] base_q, base_cur;
  logic                  end_of_row;

  // A restart coinciding with an accept must address pair 0 of the new frame.
  always_comb begin
    row_cur      = restart ? 10'd0 : row_q;
    col_cur      = restart ? 10'd0 : col_q;
    base_cur     = restart ? BASE_FIRST : base_q;
    end_of_row   = (col_cur == COL_LAST);
    end_of_frame = end_of_row && (row_cur == ROW_LAST);
    addr         = base_cur + ADDR_WIDTH'(col_cur);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= BASE_FIRST;
    end else if (accept) begin
      if (end_of_row) begin
        col_q  <= '0;
        row_q  <= row_cur + 10'd1;
        base_q <= base_cur - ROW_STEP;
      end else begin
        col_q  <= col_cur + 10'd1;
        row_q  <= row_cur;
        base_q <= base_cur;
      end
    end else if (restart) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= BASE_FIRST;
    end
  end
endmodule

// File: rtl/write_data.sv
// Frame writer: takes pixel pairs framed by vsync and writes them bottom-up
// into a 48-bit frame buffer, flagging frame completion and framing errors.
//
//   state         | meaning
//   STATE_IDLE    | no frame yet; waiting for vsync rise
//   STATE_CAPTURE | accepting pairs, one write per horizontal_Pulse
//   STATE_DONE    | frame complete; done_Flag held until next vsync rise
module write_data
  import write_data_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18
) (
  input logic         clk,
  input logic         reset,
  write_data_if.slave pix
);
  state_t                state;
  logic                  vsync_q;
  logic                  vsync_rise;
  logic                  accept;
  logic                  end_of_frame;
  logic [ADDR_WIDTH-1:0] gen_addr;

  assign vsync_rise = pix.vertical_Pulse & ~vsync_q;
  assign accept     = (state == STATE_CAPTURE) & pix.horizontal_Pulse;

  bmp_addr_gen #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .restart     (vsync_rise),
    .accept      (accept),
    .addr        (gen_addr),
    .end_of_frame(end_of_frame)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= STATE_IDLE;
      vsync_q          <= 1'b0;
      pix.write_Enable <= 1'b0;
      pix.write_Addr   <= '0;
      pix.write_Data   <= '0;
      pix.done_Flag    <= 1'b0;
      pix.frame_Error  <= 1'b0;
    end else begin
      vsync_q          <= pix.vertical_Pulse;
      pix.write_Enable <= 1'b0;
      case (state)
        STATE_IDLE, STATE_DONE: begin
          // Pairs outside a frame are dropped, even alongside a vsync rise.
          if (pix.horizontal_Pulse) pix.frame_Error <= 1'b1;
          if (vsync_rise) begin
            state         <= STATE_CAPTURE;
            pix.done_Flag <= 1'b0;
          end
        end
        STATE_CAPTURE: begin
          if (vsync_rise) pix.frame_Error <= 1'b1;
          if (pix.horizontal_Pulse) begin
            pix.write_Enable <= 1'b1;
            pix.write_Addr   <= gen_addr;
            pix.write_Data   <= pack_pair(pix.data_R_Even, pix.data_G_Even, pix.data_B_Even,
                                          pix.data_R_Odd, pix.data_G_Odd, pix.data_B_Odd);
            if (end_of_frame) begin
              state         <= STATE_DONE;
              pix.done_Flag <= 1'b1;
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_data.sv
// Bench for write_data on an 8x4 image: constant vector table, hand sequences
// for short frame / stray data / async reset, and a randomized phase vs a model.
module tb_write_data;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int AW  = 4;
  localparam int PPR = W / 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  write_data_if #(.ADDR_WIDTH(AW)) pix ();

  write_data #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .pix  (pix)
  );

  typedef struct {
    logic        vp, hp;
    logic [7:0]  re, ge, be, ro, go, bo;
    logic        exp_we;
    logic [AW-1:0] exp_addr;
    logic [47:0] exp_data;
    logic        exp_done, exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  // behavioural model: frame state as booleans, address from pair index
  logic        m_vs, m_active, m_done, m_err, m_we;
  int          m_n, m_writes;
  logic [AW-1:0] m_addr;
  logic [47:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vs = 0; m_active = 0; m_done = 0; m_err = 0; m_we = 0;
    m_n = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic drive_cycle(input logic vp, input logic hp,
                             input logic [7:0] re, input logic [7:0] ge, input logic [7:0] be,
                             input logic [7:0] ro, input logic [7:0] go, input logic [7:0] bo);
    bit rise;
    @(negedge clk);
    pix.vertical_Pulse = vp; pix.horizontal_Pulse = hp;
    pix.data_R_Even = re; pix.data_G_Even = ge; pix.data_B_Even = be;
    pix.data_R_Odd  = ro; pix.data_G_Odd  = go; pix.data_B_Odd  = bo;
    rise = vp && !m_vs;
    m_vs = vp;
    m_we = 0;
    if (m_active) begin
      if (rise) begin m_err = 1; m_n = 0; end
      if (hp) begin
        m_we   = 1;
        m_addr = AW'((H - 1 - m_n / PPR) * PPR + m_n % PPR);
        m_data = {ro, go, bo, re, ge, be};
        m_n++;
        m_writes++;
        if (m_n == W * H / 2) begin m_active = 0; m_done = 1; end
      end
    end else begin
      if (hp) m_err = 1;
      if (rise) begin m_active = 1; m_done = 0; m_n = 0; end
    end
    @(posedge clk);
    #1;
    if (pix.write_Enable) n_writes++;
  endtask

  task automatic check_model();
    check("model_we",   64'(pix.write_Enable), 64'(m_we));
    check("model_addr", 64'(pix.write_Addr),   64'(m_addr));
    check("model_data", 64'(pix.write_Data),   64'(m_data));
    check("model_done", 64'(pix.done_Flag),    64'(m_done));
    check("model_err",  64'(pix.frame_Error),  64'(m_err));
  endtask

  task automatic simple(input logic vp, input logic hp);
    drive_cycle(vp, hp, 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom));
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},   64'(pix.write_Enable), 64'd0);
    check({tag, "_addr"}, 64'(pix.write_Addr),   64'd0);
    check({tag, "_data"}, 64'(pix.write_Data),   64'd0);
    check({tag, "_done"}, 64'(pix.done_Flag),    64'd0);
    check({tag, "_err"},  64'(pix.frame_Error),  64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix.vertical_Pulse = 0; pix.horizontal_Pulse = 0;
    reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  vec_t vecs[18];
  int   addr_list[16] = '{12, 13, 14, 15, 8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

  initial begin
    int acc;
    logic vp_r;
    pix.vertical_Pulse = 0; pix.horizontal_Pulse = 0;
    pix.data_R_Even = 0; pix.data_G_Even = 0; pix.data_B_Even = 0;
    pix.data_R_Odd = 0; pix.data_G_Odd = 0; pix.data_B_Odd = 0;
    model_reset();
    m_writes = 0;

    // full-frame vector table
    vecs[0] = '{vp:1, hp:0, re:0, ge:0, be:0, ro:0, go:0, bo:0,
                exp_we:0, exp_addr:0, exp_data:48'h0, exp_done:0, exp_err:0};
    vecs[1] = '{vp:1, hp:1, re:8'h11, ge:8'h22, be:8'h33, ro:8'h44, go:8'h55, bo:8'h66,
                exp_we:1, exp_addr:AW'(12), exp_data:48'h445566112233, exp_done:0, exp_err:0};
    for (int i = 2; i <= 16; i++) begin
      vecs[i] = '{vp:1, hp:1, re:8'(i), ge:8'(i + 16), be:8'(i + 32),
                  ro:8'(i + 128), go:8'(i + 160), bo:8'(i + 192),
                  exp_we:1, exp_addr:AW'(addr_list[i-1]),
                  exp_data:{8'(i + 128), 8'(i + 160), 8'(i + 192), 8'(i), 8'(i + 16), 8'(i + 32)},
                  exp_done:(i == 16), exp_err:0};
    end
    vecs[17] = '{vp:1, hp:0, re:0, ge:0, be:0, ro:0, go:0, bo:0,
                 exp_we:0, exp_addr:AW'(3), exp_data:vecs[16].exp_data, exp_done:1, exp_err:0};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 18; i++) begin
      drive_cycle(vecs[i].vp, vecs[i].hp, vecs[i].re, vecs[i].ge, vecs[i].be,
                  vecs[i].ro, vecs[i].go, vecs[i].bo);
      check($sformatf("vec%0d_we", i),   64'(pix.write_Enable), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_addr", i), 64'(pix.write_Addr),   64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i), 64'(pix.write_Data),   64'(vecs[i].exp_data));
      check($sformatf("vec%0d_done", i), 64'(pix.done_Flag),    64'(vecs[i].exp_done));
      check($sformatf("vec%0d_err", i),  64'(pix.frame_Error),  64'(vecs[i].exp_err));
    end

    // stray pair in DONE
    simple(1, 1);
    check("done_stray_we",   64'(pix.write_Enable), 64'd0);
    check("done_stray_done", 64'(pix.done_Flag),    64'd1);
    check("done_stray_err",  64'(pix.frame_Error),  64'd1);

    // stray pair in IDLE
    do_reset();
    simple(0, 1);
    check("idle_stray_we",  64'(pix.write_Enable), 64'd0);
    check("idle_stray_err", 64'(pix.frame_Error),  64'd1);

    // short frame: 5 pairs, then vsync rise with a pair
    do_reset();
    simple(1, 0);
    for (int i = 0; i < 5; i++) simple(1, 1);
    check("short_5th_addr", 64'(pix.write_Addr), 64'd8);
    check("short_err_before", 64'(pix.frame_Error), 64'd0);
    simple(0, 0);
    simple(1, 1);
    check("short_restart_we",   64'(pix.write_Enable), 64'd1);
    check("short_restart_addr", 64'(pix.write_Addr),   64'd12);
    check("short_restart_err",  64'(pix.frame_Error),  64'd1);
    for (int i = 0; i < 15; i++) simple(1, 1);
    check("short_last_addr", 64'(pix.write_Addr),  64'd3);
    check("short_last_done", 64'(pix.done_Flag),   64'd1);
    check("short_last_err",  64'(pix.frame_Error), 64'd1);

    // async reset mid-row, between edges
    simple(0, 0);
    simple(1, 0);
    simple(1, 1);
    simple(1, 1);
    #2 reset = 0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    pix.vertical_Pulse = 0;
    @(negedge clk);
    reset = 1;
    n_writes = 0;
    for (int i = 0; i < 4; i++) simple(0, 1);
    check("post_reset_writes", 64'(n_writes), 64'd0);
    simple(1, 0);
    simple(1, 1);
    check("post_reset_first_addr", 64'(pix.write_Addr), 64'd12);

    // gapped input: writes must equal accepted pairs, addresses contiguous
    do_reset();
    simple(1, 0);
    n_writes = 0;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      logic hp;
      hp = 1'($urandom_range(0, 1));
      if (hp && m_active) acc++;
      simple(1, hp);
    end
    check("gap_write_count", 64'(n_writes), 64'(acc));

    // randomized phase with occasional vsync toggles
    do_reset();
    vp_r = 0;
    m_writes = 0;
    n_writes = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 29) == 0) vp_r = ~vp_r;
      simple(vp_r, $urandom_range(0, 3) != 0);
    end
    check("rand_write_count", 64'(n_writes), 64'(m_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
